// File: rtl/nibble_fetch_unit_if.sv
// Fetch-stage bus: program ROM port, control inputs and the decoded instruction outputs.
// The master modport is the fetch unit; the slave modport is the surrounding datapath/ROM.
interface nibble_fetch_unit_if #(
    parameter int PC_WIDTH = 12
);
    logic [7:0]          rom_data;
    logic [PC_WIDTH-1:0] rom_addr;
    logic                jump_en;
    logic [PC_WIDTH-1:0] jump_addr;
    logic                halt;
    logic                phase;
    logic [3:0]          opcode;
    logic [3:0]          operand;
    logic                ir_valid;

    modport master (
        input  rom_data,
        input  jump_en,
        input  jump_addr,
        input  halt,
        output rom_addr,
        output phase,
        output opcode,
        output operand,
        output ir_valid
    );

    modport slave (
        output rom_data,
        output jump_en,
        output jump_addr,
        output halt,
        input  rom_addr,
        input  phase,
        input  opcode,
        input  operand,
        input  ir_valid
    );
endinterface

// File: rtl/nibble_fetch_unit.sv
// Instruction fetch stage: PC, instruction register and a two-phase FETCH/EXECUTE sequencer.
// Every output is a register or a direct decode of one; no input reaches an output combinationally.
module nibble_fetch_unit #(
    parameter int                  PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   Rst,
    nibble_fetch_unit_if.master    bus
);
    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } phase_t;

    phase_t              phase_reg;
    logic [PC_WIDTH-1:0] pc_reg;
    logic [7:0]          ir_reg;

    always_ff @(posedge clk) begin
        if (Rst) begin
            pc_reg    <= RESET_PC;
            ir_reg    <= 8'h00;
            phase_reg <= FETCH;
        end else if (phase_reg == FETCH) begin
            // halt freezes everything; the IR keeps the previous instruction visible
            if (!bus.halt) begin
                ir_reg    <= bus.rom_data;
                pc_reg    <= pc_reg + PC_WIDTH'(1);
                phase_reg <= EXECUTE;
            end
        end else begin
            // PC was already advanced during FETCH, so only a jump changes it here
            if (bus.jump_en) begin
                pc_reg <= bus.jump_addr;
            end
            phase_reg <= FETCH;
        end
    end

    assign bus.rom_addr = pc_reg;
    assign bus.phase    = phase_reg;
    assign bus.ir_valid = (phase_reg == EXECUTE);
    assign bus.opcode   = ir_reg[7:4];
    assign bus.operand  = ir_reg[3:0];
endmodule

// File: tb/tb_nibble_fetch_unit.sv
// Table-driven check of nibble_fetch_unit with a scoreboard of expected fetched instructions.
module tb_nibble_fetch_unit;
    logic clk;
    logic Rst;

    nibble_fetch_unit_if #(.PC_WIDTH(12)) bus ();

    nibble_fetch_unit #(.PC_WIDTH(12), .RESET_PC(12'h000)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench ROM; returns 8'hAB whenever reset is held so reset must ignore rom_data
    logic [7:0] rom_mem [0:4095];
    assign bus.rom_data = Rst ? 8'hAB : rom_mem[bus.rom_addr];

    typedef struct {
        logic        rst;
        logic        halt;
        logic        jump_en;
        logic [11:0] jump_addr;
        logic [11:0] e_addr;
        logic        e_phase;
        logic [7:0]  e_ir;
    } vec_t;

    vec_t       tbl [18];
    logic [7:0] exp_q [$];
    logic [11:0] model_addr;
    int         pass_cnt;
    int         total_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [7:0] sb_exp;
        Rst           = v.rst;
        bus.halt      = v.halt;
        bus.jump_en   = v.jump_en;
        bus.jump_addr = v.jump_addr;
        if (!v.rst && v.e_phase) begin
            exp_q.push_back(rom_mem[model_addr]);
        end
        @(posedge clk);
        #1;
        $display("txn %s: rst=%0b halt=%0b jmp=%0b/%03h -> addr=%03h ph=%0b op=%0h opd=%0h iv=%0b",
                 tag, v.rst, v.halt, v.jump_en, v.jump_addr,
                 bus.rom_addr, bus.phase, bus.opcode, bus.operand, bus.ir_valid);
        check({tag, " rom_addr"}, 32'(bus.rom_addr), 32'(v.e_addr));
        check({tag, " phase"},    32'(bus.phase),    32'(v.e_phase));
        check({tag, " opcode"},   32'(bus.opcode),   32'(v.e_ir[7:4]));
        check({tag, " operand"},  32'(bus.operand),  32'(v.e_ir[3:0]));
        check({tag, " ir_valid"}, 32'(bus.ir_valid), 32'(v.e_phase));
        if (bus.ir_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL %s scoreboard: got instr %02h expected none", tag, {bus.opcode, bus.operand});
            end else begin
                sb_exp = exp_q.pop_front();
                check({tag, " scoreboard"}, 32'({bus.opcode, bus.operand}), 32'(sb_exp));
            end
        end
        model_addr = v.e_addr;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        model_addr    = 12'h000;
        Rst           = 1'b1;
        bus.halt      = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_addr = 12'h000;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
        rom_mem[12'h000] = 8'h35;
        rom_mem[12'h001] = 8'h6A;
        rom_mem[12'h002] = 8'hF0;
        rom_mem[12'h003] = 8'h9C;
        rom_mem[12'h005] = 8'hC7;
        rom_mem[12'h07F] = 8'h5E;
        rom_mem[12'hFFF] = 8'h12;

        //         rst   halt  jmp   jaddr     e_addr    e_ph  e_ir
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 1'b1, 8'h35};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 1'b0, 8'h35};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h002, 1'b1, 8'h6A};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h002, 1'b0, 8'h6A};  // halt in EXECUTE ignored
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 12'h200, 12'h003, 1'b1, 8'hF0};  // jump in FETCH ignored
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h003, 1'b0, 8'hF0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h004, 1'b1, 8'h9C};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 12'h07F, 12'h07F, 1'b0, 8'h9C};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h080, 1'b1, 8'h5E};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 12'h005, 12'h005, 1'b0, 8'h5E};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h005, 1'b0, 8'h5E};  // halt x3 at PC=5
        tbl[13] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h005, 1'b0, 8'h5E};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h005, 1'b0, 8'h5E};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h006, 1'b1, 8'hC7};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 12'h200, 12'h000, 1'b0, 8'h00};  // reset beats jump in EXECUTE
        tbl[17] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 1'b1, 8'h35};

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Wrap-around: 12'hFFF increments to 0
        apply('{1'b0, 1'b0, 1'b1, 12'hFFF, 12'hFFF, 1'b0, 8'h35}, "wrap_jump");
        rom_mem[12'h000] = 8'h34;
        apply('{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 8'h12}, "wrap_fetch_fff");
        apply('{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 8'h12}, "wrap_exec");
        apply('{1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 1'b1, 8'h34}, "wrap_fetch_0");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
